// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register and EX-stage operand network for the
//                RV32I core. Captures decoded fields once per cycle, forwards
//                EX/MEM and MEM/WB results onto both source operands, applies
//                the asel/bsel operand selection for the ALU, detects load-use
//                hazards and handles stall/flush bubbles.
//
//  Ports       :
//    clk, rst                 clock (rising edge), synchronous active-high reset
//    stall, flush             hold stage / replace next contents with a bubble
//    id_*                     decoded instruction fields from the ID stage
//    exm_regwen/rd/data       EX/MEM forwarding source
//    wb_regwen/rd/data        MEM/WB forwarding source
//    alu_a, alu_b, alusel     ALU operands (combinational) and registered op
//    ex_*                     registered control / PC passed downstream
//    ex_store_data            forwarded rs2 value for stores
//    load_use                 combinational; IF/ID must hold when high
//
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic [3:0]       id_alusel,
    input  logic             id_asel,
    input  logic             id_bsel,
    input  logic             id_regwen,
    input  logic             id_memrw,
    input  logic             id_memread,
    input  logic [1:0]       id_wbsel,
    input  logic             exm_regwen,
    input  logic [RADDR-1:0] exm_rd,
    input  logic [XLEN-1:0]  exm_data,
    input  logic             wb_regwen,
    input  logic [RADDR-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alusel,
    output logic             ex_valid,
    output logic             ex_regwen,
    output logic             ex_memrw,
    output logic             ex_memread,
    output logic [RADDR-1:0] ex_rd,
    output logic [1:0]       ex_wbsel,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_store_data,
    output logic             load_use
);

    localparam logic [RADDR-1:0] c_X0 = '0;

    // ------------------------------------------------------------------------
    // Pipeline register state
    // ------------------------------------------------------------------------
    logic             r_valid;
    logic             r_regwen;
    logic             r_memrw;
    logic             r_memread;
    logic [3:0]       r_alusel;
    logic [RADDR-1:0] r_rd;
    logic [1:0]       r_wbsel;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [RADDR-1:0] r_rs1;
    logic [RADDR-1:0] r_rs2;
    logic             r_asel;
    logic             r_bsel;

    logic             w_load_use;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // A load in EX whose destination is read by the instruction in ID.
    // id_valid is deliberately ignored: a false match only costs one bubble.
    assign w_load_use = r_valid & r_memread & (r_rd != c_X0) &
                        ((r_rd == id_rs1) | (r_rd == id_rs2));

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && w_load_use)) begin
            // Reset, flush and load-use all leave a bubble: every field zero.
            r_valid    <= 1'b0;
            r_regwen   <= 1'b0;
            r_memrw    <= 1'b0;
            r_memread  <= 1'b0;
            r_alusel   <= 4'd0;
            r_rd       <= '0;
            r_wbsel    <= 2'd0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_asel     <= 1'b0;
            r_bsel     <= 1'b0;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_regwen   <= id_regwen;
            r_memrw    <= id_memrw;
            r_memread  <= id_memread;
            r_alusel   <= id_alusel;
            r_rd       <= id_rd;
            r_wbsel    <= id_wbsel;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_asel     <= id_asel;
            r_bsel     <= id_bsel;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding: EX/MEM is younger than MEM/WB so it wins; x0 never forwards.
    // Stays live during stall so operands track the later stages.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exm_regwen && (exm_rd != c_X0) && (exm_rd == r_rs1)) begin
            w_fwd_rs1 = exm_data;
        end else if (wb_regwen && (wb_rd != c_X0) && (wb_rd == r_rs1)) begin
            w_fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (exm_regwen && (exm_rd != c_X0) && (exm_rd == r_rs2)) begin
            w_fwd_rs2 = exm_data;
        end else if (wb_regwen && (wb_rd != c_X0) && (wb_rd == r_rs2)) begin
            w_fwd_rs2 = wb_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_a         = r_asel ? r_pc  : w_fwd_rs1;
    assign alu_b         = r_bsel ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign alusel        = r_alusel;
    assign ex_valid      = r_valid;
    assign ex_regwen     = r_regwen;
    assign ex_memrw      = r_memrw;
    assign ex_memread    = r_memread;
    assign ex_rd         = r_rd;
    assign ex_wbsel      = r_wbsel;
    assign ex_pc         = r_pc;
    assign load_use      = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: directed scenarios with
//                constant expectations, then randomized traffic against a
//                behavioural model of the stage contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        id_valid, id_asel, id_bsel, id_regwen, id_memrw, id_memread;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alusel;
    logic [1:0]  id_wbsel;
    logic        exm_regwen, wb_regwen;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;
    logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
    logic [3:0]  alusel;
    logic        ex_valid, ex_regwen, ex_memrw, ex_memread, load_use;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_wbsel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alusel(id_alusel), .id_asel(id_asel), .id_bsel(id_bsel),
        .id_regwen(id_regwen), .id_memrw(id_memrw), .id_memread(id_memread),
        .id_wbsel(id_wbsel),
        .exm_regwen(exm_regwen), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_regwen(wb_regwen), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alusel(alusel),
        .ex_valid(ex_valid), .ex_regwen(ex_regwen), .ex_memrw(ex_memrw),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_wbsel(ex_wbsel),
        .ex_pc(ex_pc), .ex_store_data(ex_store_data), .load_use(load_use)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0;
        id_valid = 0; id_asel = 0; id_bsel = 0; id_regwen = 0; id_memrw = 0;
        id_memread = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alusel = 0; id_wbsel = 0;
        exm_regwen = 0; exm_rd = 0; exm_data = 0;
        wb_regwen = 0; wb_rd = 0; wb_data = 0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: the EX slot as a record of what was accepted.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        valid, regwen, memrw, memread;
        logic [3:0]  alusel;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2;
        logic        asel, bsel;
    } ex_t;

    ex_t m;

    // Value a consumer of register 'a' should see: newest producer first.
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (exm_regwen && exm_rd != 0 && exm_rd == a) return exm_data;
        if (wb_regwen && wb_rd != 0 && wb_rd == a)    return wb_data;
        return v;
    endfunction

    function automatic logic model_lu();
        return m.valid && m.memread && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    function automatic ex_t from_id();
        ex_t e;
        e.valid = id_valid; e.regwen = id_regwen; e.memrw = id_memrw;
        e.memread = id_memread; e.alusel = id_alusel; e.rd = id_rd;
        e.wbsel = id_wbsel; e.pc = id_pc; e.r1d = id_rs1_data; e.r2d = id_rs2_data;
        e.imm = id_imm; e.rs1 = id_rs1; e.rs2 = id_rs2; e.asel = id_asel; e.bsel = id_bsel;
        return e;
    endfunction

    task automatic randomize_inputs();
        rst         = ($urandom_range(0, 31) == 0);
        flush       = ($urandom_range(0, 7) == 0);
        stall       = ($urandom_range(0, 4) == 0);
        id_valid    = ($urandom_range(0, 5) != 0);
        id_asel     = $urandom_range(0, 1);
        id_bsel     = $urandom_range(0, 1);
        id_regwen   = $urandom_range(0, 1);
        id_memrw    = $urandom_range(0, 1);
        id_memread  = ($urandom_range(0, 2) == 0);
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rs1      = 5'($urandom_range(0, 7));
        id_rs2      = 5'($urandom_range(0, 7));
        id_rd       = 5'($urandom_range(0, 7));
        id_alusel   = 4'($urandom_range(0, 11));
        id_wbsel    = 2'($urandom_range(0, 3));
        exm_regwen  = $urandom_range(0, 1);
        exm_rd      = 5'($urandom_range(0, 7));
        exm_data    = $urandom;
        wb_regwen   = $urandom_range(0, 1);
        wb_rd       = 5'($urandom_range(0, 7));
        wb_data     = $urandom;
    endtask

    initial begin
        idle_inputs();

        // ---- Reset with a live instruction at the input ----
        rst = 1; id_valid = 1; id_alusel = 4'b0101;
        tick(); tick();
        chk("rst_valid",   {31'd0, ex_valid}, 32'd0);
        chk("rst_alusel",  {28'd0, alusel},   32'd0);
        chk("rst_alu_a",   alu_a,             32'd0);
        chk("rst_alu_b",   alu_b,             32'd0);
        chk("rst_lu",      {31'd0, load_use}, 32'd0);

        // ---- Basic load ----
        rst = 0; id_rs1 = 1; id_rs2 = 2; id_rd = 5;
        id_rs1_data = 5; id_rs2_data = 7; id_alusel = 4'b0000;
        tick();
        chk("basic_a",      alu_a,             32'd5);
        chk("basic_b",      alu_b,             32'd7);
        chk("basic_alusel", {28'd0, alusel},   32'd0);
        chk("basic_valid",  {31'd0, ex_valid}, 32'd1);

        // ---- Forwarding priority on rs1 = x3 ----
        id_rs1 = 3; id_rs1_data = 32'h33;
        tick();
        stall = 1;
        exm_regwen = 1; exm_rd = 3; exm_data = 32'h11;
        wb_regwen = 1;  wb_rd = 3;  wb_data = 32'h22;
        #1 chk("fwd_exm", alu_a, 32'h11);
        exm_regwen = 0;
        #1 chk("fwd_wb", alu_a, 32'h22);
        exm_regwen = 1; exm_rd = 0; wb_rd = 0;
        #1 chk("fwd_x0", alu_a, 32'h33);

        // ---- Load-use ----
        stall = 0; exm_regwen = 0; wb_regwen = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 4; id_memread = 1;
        tick();
        id_memread = 0; id_rs2 = 4; id_rd = 6;
        #1 chk("lu_hit", {31'd0, load_use}, 32'd1);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        id_rs2 = 0;
        #1 chk("lu_clear", {31'd0, load_use}, 32'd0);

        // ---- Stall vs flush ----
        id_rs1 = 3; id_rs1_data = 32'h44; id_alusel = 4'd3; id_rd = 7;
        tick();
        chk("st_load", {28'd0, alusel}, 32'd3);
        stall = 1; id_alusel = 4'd9; id_rs1_data = 32'h99; exm_regwen = 1; exm_rd = 3;
        for (int i = 0; i < 3; i++) begin
            exm_data = 32'h100 + i;
            #1 chk("st_fwd", alu_a, 32'h100 + i);
            tick();
            chk("st_hold_op", {28'd0, alusel}, 32'd3);
            chk("st_hold_rd", {27'd0, ex_rd},  32'd7);
        end
        flush = 1;
        tick();
        chk("fl_valid",  {31'd0, ex_valid}, 32'd0);
        chk("fl_alusel", {28'd0, alusel},   32'd0);

        // ---- Operand select ----
        stall = 0; flush = 0; exm_regwen = 0;
        id_asel = 1; id_bsel = 1; id_pc = 32'h100; id_imm = 32'hFFFF_FFFC;
        id_rs1 = 1; id_rs2 = 2; id_rs2_data = 32'h77; id_alusel = 0; id_rd = 8;
        tick();
        exm_regwen = 1; exm_rd = 2; exm_data = 32'h55;
        #1;
        chk("sel_a",     alu_a,         32'h100);
        chk("sel_b",     alu_b,         32'hFFFF_FFFC);
        chk("sel_store", ex_store_data, 32'h55);
        chk("sel_pc",    ex_pc,         32'h100);

        // ---- Randomized traffic against the model ----
        idle_inputs();
        rst = 1;
        tick();
        m = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ex_t nxt;
            randomize_inputs();
            #1;
            chk("r_lu",     {31'd0, load_use}, {31'd0, model_lu()});
            chk("r_alu_a",  alu_a, m.asel ? m.pc : fwd(m.rs1, m.r1d));
            chk("r_alu_b",  alu_b, m.bsel ? m.imm : fwd(m.rs2, m.r2d));
            chk("r_store",  ex_store_data, fwd(m.rs2, m.r2d));
            chk("r_pc",     ex_pc, m.pc);
            chk("r_ctrl",   {16'd0, ex_valid, ex_regwen, ex_memrw, ex_memread,
                             ex_wbsel, ex_rd, alusel},
                            {16'd0, m.valid, m.regwen, m.memrw, m.memread,
                             m.wbsel, m.rd, m.alusel});
            if (rst || flush)   nxt = '0;
            else if (stall)     nxt = m;
            else if (model_lu()) nxt = '0;
            else                nxt = from_id();
            tick();
            m = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
